uart_echo_checker: RTL and testbench
====================================

Name: uart_echo_checker

Overview:
- Synthesizable self-checking echo tester. Drives a programmable byte pattern into the ready/valid transmit side of the UART and checks that every byte returns unchanged on its receive side.
- Supports multiple bytes in flight, with a bounded expected-byte queue.
- Reports pass/fail, error count, first mismatch and timeout.
- Used on the FPGA and in simulation to exercise the Riscv150 echo program without a host script.

Parameters:
- COUNT_W, 16, width of byte-count and error-count fields.
- MAX_OUTSTANDING, 4, max bytes sent but not yet echoed; power of 2, ≥1.
- TIMEOUT_CYCLES, 2000000, idle cycles with outstanding bytes before declaring timeout.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  synchronous, active-low reset (asserted when 0, sampled on rising Clock).
- Start  in  1  one-cycle request to begin a run; honoured only when not Busy.
- Mode  in  2  pattern: 0 constant, 1 increment, 2 LFSR, 3 alternate Seed/~Seed.
- Seed  in  8  first pattern byte; sampled at Start.
- Count  in  COUNT_W  bytes to send; sampled at Start.
- TxData  out  8  byte to UART DataIn.
- TxValid  out  1  to UART DataInValid.
- TxReady  in  1  from UART DataInReady.
- RxData  in  8  from UART DataOut.
- RxValid  in  1  from UART DataOutValid.
- RxReady  out  1  to UART DataOutReady.
- Busy  out  1  run in progress.
- Done  out  1  run finished; held until next accepted Start.
- Pass  out  1  Done and ErrorCount==0 and not TimedOut.
- TimedOut  out  1  run ended by timeout.
- ErrorCount  out  COUNT_W  mismatches plus stray bytes; saturating.
- RxCount  out  COUNT_W  bytes received during run.
- FirstExp  out  8  expected byte at first mismatch.
- FirstGot  out  8  received byte at first mismatch.

Behaviour:
- Reset (Reset==0):
  - State IDLE; all outputs 0 except RxReady=1.
  - Expected queue emptied; pattern generator cleared.
- States: IDLE, RUN, DONE. RxReady=1 in every state. All outputs registered.
- IDLE/DONE + Start:
  - Latch Mode, Seed (Mode 2 with Seed==0 substitutes 8'h01) and Count.
  - Clear ErrorCount, RxCount, First*, TimedOut, Done.
  - Enter RUN; Busy=1 next cycle.
- Start with Count==0: go directly to DONE; Done=1, Pass=1 next cycle.
- Start while in RUN: ignored.
- RUN transmit:
  - TxValid=1 while sent<Count and queue not full.
  - TxData is the current pattern byte and is held stable until the handshake.
  - On TxValid&&TxReady: push TxData to the queue, advance the pattern, sent++.
  - First TxValid appears the cycle after entering RUN.
- Pattern advance:
  - Mode 0: unchanged.
  - Mode 1: +1, wrapping 8'hFF→8'h00.
  - Mode 2: Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, shift left, new bit0 = b7^b5^b4^b3.
  - Mode 3: bitwise invert.
- RUN receive, on RxValid (RxReady=1):
  - RxCount++.
  - Queue non-empty: pop and compare. Mismatch → ErrorCount++; on the first error only, capture FirstExp/FirstGot.
  - Queue empty: stray byte → ErrorCount++, FirstExp=8'h00 if first error.
- Simultaneous push and pop in one cycle: both happen; occupancy unchanged; a full queue accepts the push only if a pop occurs in the same cycle.
- Bytes received in IDLE/DONE are discarded; counters unchanged.
- Timeout:
  - Counter cleared on every received byte and whenever the queue is empty; increments otherwise.
  - Reaching TIMEOUT_CYCLES-1 → DONE with TimedOut=1.
- Normal completion: sent==Count and queue empty → DONE next cycle. Done=1, Busy=0, TxValid=0.
- ErrorCount and RxCount saturate at all-ones.
- Reset mid-run aborts immediately to reset values; a partially transmitted UART byte is not tracked.

Decomposition:
- Shared package: mode encodings (MODE_CONST/INC/LFSR/ALT), state encoding, LFSR tap constant.
- Sub-module echo_expect_fifo: synchronous FIFO, 8-bit × MAX_OUTSTANDING.
  - Push/pop/full/empty, with simultaneous push+pop when full.
  - Same Clock and active-low synchronous Reset.

Test Plan:
- Loopback (TxData→RxData through UART pair), Mode 1, Seed 8'hFE, Count 4 → bytes FE,FF,00,01 sent in order; Done=1, Pass=1, RxCount=4, ErrorCount=0.
- Mode 2, Seed 0, Count 3 → TxData 01,02,04; Pass=1.
- Echo path corrupting the 2nd byte (0x7A→0x7B), Mode 0, Seed 7A, Count 3 → ErrorCount=1, FirstExp=7A, FirstGot=7B, Pass=0.
- Echo path silent, Count 5, MAX_OUTSTANDING 4, TIMEOUT_CYCLES 100 → exactly 4 bytes sent; TimedOut=1 about 100 cycles after last send; Pass=0.
- Stray RxValid byte in IDLE, then Count 0 Start → counters stay 0; Done=1, Pass=1 one cycle after Start.
- Reset=0 held 2 cycles mid-run (after 2 of 6 bytes) → Busy=0, TxValid=0, queue empty; fresh Start with Count 2 → Pass=1.

Source files
------------

// File: rtl/uart_echo_checker_pkg.sv
// Shared types for the UART echo checker: pattern modes, FSM states and the
// pattern-advance rule used by the transmit side.
package uart_echo_checker_pkg;

    typedef enum logic [1:0] {
        MODE_CONST = 2'd0,
        MODE_INC   = 2'd1,
        MODE_LFSR  = 2'd2,
        MODE_ALT   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // x^8+x^6+x^5+x^4+1: feedback from bits 7,5,4,3 into bit 0
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [7:0] next_pattern(input mode_e mode, input logic [7:0] b);
        logic [7:0] r;
        unique case (mode)
            MODE_INC:  r = b + 8'd1;
            MODE_LFSR: r = {b[6:0], ^(b & LFSR_TAPS)};
            MODE_ALT:  r = ~b;
            default:   r = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/uart_echo_checker_expect_fifo.sv
// Expected-byte queue: bytes sent but not yet echoed. A full queue still
// accepts a push when a pop happens in the same cycle.
module echo_expect_fifo #(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned LW = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clear,
    input  logic          i_push,
    input  logic [7:0]    i_data,
    input  logic          i_pop,
    output logic [7:0]    o_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [LW-1:0] o_level
);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [LW-1:0] r_level;
    logic          w_do_pop;
    logic          w_do_push;

    assign w_do_pop  = i_pop && (r_level != '0);
    assign w_do_push = i_push && ((r_level != LW'(DEPTH)) || w_do_pop);

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_do_push) r_wr <= ptr_inc(r_wr);
            if (w_do_pop)  r_rd <= ptr_inc(r_rd);
            r_level <= r_level + LW'(w_do_push) - LW'(w_do_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr] <= i_data;
    end

    assign o_data  = r_mem[r_rd];
    assign o_full  = (r_level == LW'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;

endmodule

// File: rtl/uart_echo_checker.sv
// Self-checking UART echo tester: streams a byte pattern out of the transmit
// handshake and checks each byte returned on the receive side, in order.
module uart_echo_checker
    import uart_echo_checker_pkg::*;
#(
    parameter int unsigned COUNT_W         = 16,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 2000000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [1:0]         i_mode,
    input  logic [7:0]         i_seed,
    input  logic [COUNT_W-1:0] i_count,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_valid,
    output logic               o_rx_ready,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_pass,
    output logic               o_timed_out,
    output logic [COUNT_W-1:0] o_error_count,
    output logic [COUNT_W-1:0] o_rx_count,
    output logic [7:0]         o_first_exp,
    output logic [7:0]         o_first_got
);

    localparam int unsigned LW    = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_e             r_state;
    mode_e              r_mode;
    logic [COUNT_W-1:0] r_count;
    logic [COUNT_W-1:0] r_sent;
    logic [TMO_W-1:0]   r_tmo;

    logic [7:0]         w_head;
    logic               w_full;
    logic               w_empty;
    logic [LW-1:0]      w_level;
    logic               w_accept;
    logic               w_push;
    logic               w_rx;
    logic               w_pop;
    logic               w_mismatch;
    logic [COUNT_W-1:0] w_err_nx;
    logic [COUNT_W-1:0] w_sent_nx;
    logic [LW-1:0]      w_level_nx;
    logic               w_timeout;
    logic               w_finish;
    logic               w_stay_run;

    assign w_accept   = i_start && (r_state != StRun);
    assign w_push     = o_tx_valid && i_tx_ready && (!w_full || w_pop);
    assign w_rx       = (r_state == StRun) && i_rx_valid;
    assign w_pop      = w_rx && !w_empty;
    assign w_mismatch = w_rx && (w_empty || (w_head != i_rx_data));
    assign w_err_nx   = (w_mismatch && (o_error_count != '1)) ? o_error_count + 1'b1
                                                                : o_error_count;
    assign w_sent_nx  = r_sent + COUNT_W'(w_push);
    assign w_level_nx = w_level + LW'(w_push) - LW'(w_pop);
    assign w_timeout  = (r_state == StRun) && !i_rx_valid && !w_empty &&
                        (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
    assign w_finish   = (r_state == StRun) && (r_sent == r_count) && w_empty;
    assign w_stay_run = (r_state == StRun) && !w_timeout && !w_finish;

    echo_expect_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_expect (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (w_accept),
        .i_push  (w_push),
        .i_data  (o_tx_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= StIdle;
            r_mode        <= MODE_CONST;
            r_count       <= '0;
            r_sent        <= '0;
            r_tmo         <= '0;
            o_tx_data     <= '0;
            o_tx_valid    <= 1'b0;
            o_rx_ready    <= 1'b1;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_pass        <= 1'b0;
            o_timed_out   <= 1'b0;
            o_error_count <= '0;
            o_rx_count    <= '0;
            o_first_exp   <= '0;
            o_first_got   <= '0;
        end else begin
            o_rx_ready <= 1'b1;
            // Look one cycle ahead so TxValid is registered yet never overfills the queue
            o_tx_valid <= w_stay_run && (w_sent_nx < r_count) &&
                          (w_level_nx < LW'(MAX_OUTSTANDING));
            if (w_push) begin
                o_tx_data <= next_pattern(r_mode, o_tx_data);
                r_sent    <= w_sent_nx;
            end
            unique case (r_state)
                StIdle, StDone: begin
                    if (i_start) begin
                        r_mode        <= mode_e'(i_mode);
                        r_count       <= i_count;
                        r_sent        <= '0;
                        r_tmo         <= '0;
                        o_tx_data     <= (mode_e'(i_mode) == MODE_LFSR && i_seed == 8'h00)
                                         ? 8'h01 : i_seed;
                        o_error_count <= '0;
                        o_rx_count    <= '0;
                        o_first_exp   <= '0;
                        o_first_got   <= '0;
                        o_timed_out   <= 1'b0;
                        if (i_count == '0) begin
                            r_state <= StDone;
                            o_busy  <= 1'b0;
                            o_done  <= 1'b1;
                            o_pass  <= 1'b1;
                        end else begin
                            r_state <= StRun;
                            o_busy  <= 1'b1;
                            o_done  <= 1'b0;
                            o_pass  <= 1'b0;
                        end
                    end
                end
                StRun: begin
                    if (w_rx) begin
                        o_rx_count    <= (o_rx_count != '1) ? o_rx_count + 1'b1 : o_rx_count;
                        o_error_count <= w_err_nx;
                        if (w_mismatch && o_error_count == '0) begin
                            o_first_exp <= w_empty ? 8'h00 : w_head;
                            o_first_got <= i_rx_data;
                        end
                    end
                    r_tmo <= (i_rx_valid || w_empty) ? '0 : r_tmo + 1'b1;
                    if (w_timeout) begin
                        r_state     <= StDone;
                        o_busy      <= 1'b0;
                        o_done      <= 1'b1;
                        o_pass      <= 1'b0;
                        o_timed_out <= 1'b1;
                    end else if (w_finish) begin
                        r_state <= StDone;
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                        o_pass  <= (w_err_nx == '0);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_echo_checker.sv
// Directed + randomized bench for uart_echo_checker with an in-bench echo
// responder (random delay, optional corruption) and a pattern reference model.
module tb_uart_echo_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  seed = 8'h00;
    logic [15:0] count = 16'd0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timed_out;
    logic [15:0] err_cnt;
    logic [15:0] rx_cnt;
    logic [7:0]  first_exp;
    logic [7:0]  first_got;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {logic [7:0] d; int t;} echo_t;
    logic [7:0] sent_log[$];
    echo_t      pend[$];
    int         cyc = 0;
    bit         echo_en = 1'b1;
    bit         force_ready = 1'b0;
    int         corrupt_idx = -1;
    logic [7:0] corrupt_xor = 8'h00;
    bit         stray_req = 1'b0;
    logic [7:0] stray_data = 8'h00;

    uart_echo_checker #(
        .COUNT_W         (16),
        .MAX_OUTSTANDING (4),
        .TIMEOUT_CYCLES  (100)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_mode        (mode),
        .i_seed        (seed),
        .i_count       (count),
        .o_tx_data     (tx_data),
        .o_tx_valid    (tx_valid),
        .i_tx_ready    (tx_ready),
        .i_rx_data     (rx_data),
        .i_rx_valid    (rx_valid),
        .o_rx_ready    (rx_ready),
        .o_busy        (busy),
        .o_done        (done),
        .o_pass        (pass),
        .o_timed_out   (timed_out),
        .o_error_count (err_cnt),
        .o_rx_count    (rx_cnt),
        .o_first_exp   (first_exp),
        .o_first_got   (first_got)
    );

    initial forever #5 clk = ~clk;

    // Echo responder: inputs change on the falling edge, so a handshake seen
    // here is the one the DUT takes on the next rising edge.
    initial begin : responder
        logic [7:0] b;
        forever begin
            @(negedge clk);
            cyc++;
            tx_ready = force_ready ? 1'b1 : ($urandom_range(0, 3) != 0);
            rx_valid = 1'b0;
            if (tx_valid && tx_ready) begin
                b = tx_data;
                if (sent_log.size() == corrupt_idx) b = b ^ corrupt_xor;
                sent_log.push_back(tx_data);
                if (echo_en) pend.push_back('{d: b, t: cyc + $urandom_range(1, 5)});
            end
            if (stray_req) begin
                rx_valid  = 1'b1;
                rx_data   = stray_data;
                stray_req = 1'b0;
            end else if (pend.size() > 0 && pend[0].t <= cyc) begin
                rx_valid = 1'b1;
                rx_data  = pend[0].d;
                void'(pend.pop_front());
            end
        end
    end

    // Reference pattern: byte number idx of a run, straight from the mode rules.
    function automatic logic [7:0] ref_byte(input int m, input logic [7:0] s, input int idx);
        logic [7:0] b;
        b = s;
        case (m)
            1: b = 8'((int'(s) + idx) % 256);
            2: begin
                if (b == 8'h00) b = 8'h01;
                for (int k = 0; k < idx; k++) b = {b[6:0], b[7] ^ b[5] ^ b[4] ^ b[3]};
            end
            3: b = (idx % 2 == 1) ? ~s : s;
            default: b = s;
        endcase
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_start(input int m, input logic [7:0] s, input int cnt);
        @(posedge clk); #1;
        start = 1'b1;
        mode  = 2'(m);
        seed  = s;
        count = 16'(cnt);
        @(posedge clk); #1;
        start = 1'b0;
        if (cnt > 0) begin
            chk("busy_after_start", busy, 1);
            chk("txvalid_not_yet", tx_valid, 0);
            @(posedge clk); #1;
            chk("txvalid_second_cycle", tx_valid, 1);
        end
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (!done && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        chk("done_within_budget", done, 1);
    endtask

    task automatic run_case(input int m, input logic [7:0] s, input int cnt, input int cidx,
                            input logic [7:0] cx);
        int cycles;
        int exp_err;
        sent_log.delete();
        corrupt_idx = cidx;
        corrupt_xor = cx;
        do_start(m, s, cnt);
        wait_done(cnt * 20 + 200, cycles);
        exp_err = (cidx >= 0 && cidx < cnt) ? 1 : 0;
        chk("sent_count", sent_log.size(), cnt);
        for (int i = 0; i < sent_log.size() && i < cnt; i++)
            chk($sformatf("tx_byte[%0d]", i), sent_log[i], ref_byte(m, s, i));
        chk("rx_count", rx_cnt, cnt);
        chk("error_count", err_cnt, exp_err);
        chk("pass", pass, (exp_err == 0) ? 1 : 0);
        chk("timed_out", timed_out, 0);
        chk("busy_at_done", busy, 0);
        chk("txvalid_at_done", tx_valid, 0);
        if (exp_err != 0) begin
            chk("first_exp", first_exp, ref_byte(m, s, cidx));
            chk("first_got", first_got, ref_byte(m, s, cidx) ^ cx);
        end
        corrupt_idx = -1;
    endtask

    initial begin : main
        int cycles;
        int cnt;
        int cidx;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_timed_out", timed_out, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_rxcnt", rx_cnt, 0);
        chk("rst_first_exp", first_exp, 0);
        chk("rst_first_got", first_got, 0);
        chk("rst_txvalid", tx_valid, 0);
        chk("rst_txdata", tx_data, 0);
        chk("rst_rxready", rx_ready, 1);
        rst_n = 1'b1;

        // Stray byte in idle is ignored; zero-length run completes at once
        stray_data = 8'h55;
        stray_req  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_stray_rxcnt", rx_cnt, 0);
        chk("idle_stray_err", err_cnt, 0);
        do_start(0, 8'h12, 0);
        chk("cnt0_done", done, 1);
        chk("cnt0_pass", pass, 1);
        chk("cnt0_busy", busy, 0);
        chk("cnt0_rxcnt", rx_cnt, 0);

        run_case(1, 8'hFE, 4, -1, 8'h00);
        run_case(2, 8'h00, 3, -1, 8'h00);
        run_case(0, 8'h7A, 3, 1, 8'h01);

        for (int r = 0; r < 6; r++) begin
            cnt  = $urandom_range(1, 20);
            cidx = ($urandom_range(0, 1) == 1) ? $urandom_range(0, cnt - 1) : -1;
            run_case($urandom_range(0, 3), 8'($urandom), cnt, cidx, 8'($urandom_range(1, 255)));
        end

        // Silent echo path: queue fills, then timeout
        echo_en     = 1'b0;
        force_ready = 1'b1;
        sent_log.delete();
        do_start(1, 8'h10, 5);
        wait_done(400, cycles);
        chk("tmo_sent", sent_log.size(), 4);
        chk("tmo_flag", timed_out, 1);
        chk("tmo_pass", pass, 0);
        chk("tmo_rxcnt", rx_cnt, 0);
        chk("tmo_latency_ok", (cycles >= 98 && cycles <= 108) ? 1 : 0, 1);
        force_ready = 1'b0;

        // Reset mid-run after two bytes
        sent_log.delete();
        do_start(1, 8'h40, 6);
        cycles = 0;
        while (sent_log.size() < 2 && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
        chk("mid_two_sent", (sent_log.size() >= 2) ? 1 : 0, 1);
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_txvalid", tx_valid, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_rxready", rx_ready, 1);
        rst_n = 1'b1;
        pend.delete();
        echo_en = 1'b1;
        run_case(1, 8'h33, 2, -1, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
